swervolf_branch_stats: RTL

- Upstream of the Nexys A7 seven-segment display logic.
- Counts retired branches, taken branches and mispredicted branches from the SweRV core's two retire lanes.
- Presents frozen snapshot values (`o_branches`, `o_taken`) that the toplevel display multiplexes digit by digit.
- Also exposes live counters and a control/status register over a small Wishbone slave, so software can read, freeze and clear the statistics.

---
 rtl/swervolf_pkg.sv | 28 ++
 rtl/swervolf_sat_counter.sv | 38 +++
 rtl/swervolf_branch_stats.sv | 123 ++++++++++++
 3 files changed

// File: rtl/swervolf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : swervolf_pkg
// Description : Shared constants for the SweRVolf branch statistics block.
// Revision    : 1.0 - initial release
// ============================================================================
package swervolf_pkg;

    localparam int CNT_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        BSTAT_TOTAL = 2'd0,
        BSTAT_TAKEN = 2'd1,
        BSTAT_MISP  = 2'd2,
        BSTAT_CTRL  = 2'd3
    } bstat_addr_e;

    localparam int FREEZE = 0;
    localparam int OVF    = 1;
    localparam int CLEAR  = 2;

    // Number of set bits in a two-lane qualifier vector (0..2).
    function automatic logic [1:0] pop2(input logic [1:0] v);
        return {v[1] & v[0], v[1] ^ v[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/swervolf_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : swervolf_sat_counter
// Description : Event counter adding 0..2 per cycle, saturating or wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module swervolf_sat_counter #(
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] count,
    output logic             ovf_pulse
);

    logic [CNT_W:0] w_sum;

    assign w_sum     = {1'b0, count} + (CNT_W+1)'(inc);
    // Clear takes priority, so an overflow in a clear cycle never reports.
    assign ovf_pulse = en & ~clr & w_sum[CNT_W];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            if (w_sum[CNT_W] && SATURATE)
                count <= '1;
            else
                count <= w_sum[CNT_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/swervolf_branch_stats.sv
`default_nettype none
// ============================================================================
// Module      : swervolf_branch_stats
// Description : Retired/taken/mispredicted branch counters with display
//               snapshots and a Wishbone control/status slave.
// Revision    : 1.0 - initial release
// ============================================================================
module swervolf_branch_stats
    import swervolf_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       i_br_valid,
    input  logic [1:0]       i_br_taken,
    input  logic [1:0]       i_br_mispred,
    input  logic             i_snap,
    input  logic [1:0]       i_wb_adr,
    input  logic [31:0]      i_wb_dat,
    input  logic             i_wb_we,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    output logic [31:0]      o_wb_rdt,
    output logic             o_wb_ack,
    output logic [CNT_W-1:0] o_branches,
    output logic [CNT_W-1:0] o_taken,
    output logic             o_ovf
);

    logic             r_ack;
    logic [31:0]      r_rdt;
    logic             r_freeze;
    logic             r_ovf;
    logic [CNT_W-1:0] r_branches;
    logic [CNT_W-1:0] r_taken;

    logic             w_req;
    logic             w_ctrl_wr;
    logic             w_clr;
    logic             w_en;
    logic [31:0]      w_rdt;
    logic [CNT_W-1:0] w_tot_cnt, w_tk_cnt, w_mp_cnt;
    logic             w_tot_ovf, w_tk_ovf, w_mp_ovf;
    logic             w_unused;

    assign w_req     = i_wb_cyc & i_wb_stb & ~r_ack;
    assign w_ctrl_wr = w_req & i_wb_we & (i_wb_adr == BSTAT_CTRL);
    // Clear lands on the same edge that accepts the write, ahead of events.
    assign w_clr     = w_ctrl_wr & i_wb_dat[CLEAR];
    assign w_en      = ~r_freeze;
    assign w_unused  = &{1'b0, i_wb_dat[31:3], i_wb_dat[OVF]};

    swervolf_sat_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_tot_cnt (
        .clk(clk), .rst(rst), .clr(w_clr), .en(w_en),
        .inc(pop2(i_br_valid)),
        .count(w_tot_cnt), .ovf_pulse(w_tot_ovf)
    );

    swervolf_sat_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_tk_cnt (
        .clk(clk), .rst(rst), .clr(w_clr), .en(w_en),
        .inc(pop2(i_br_valid & i_br_taken)),
        .count(w_tk_cnt), .ovf_pulse(w_tk_ovf)
    );

    swervolf_sat_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_mp_cnt (
        .clk(clk), .rst(rst), .clr(w_clr), .en(w_en),
        .inc(pop2(i_br_valid & i_br_mispred)),
        .count(w_mp_cnt), .ovf_pulse(w_mp_ovf)
    );

    always_comb begin
        w_rdt = '0;
        case (i_wb_adr)
            BSTAT_TOTAL: w_rdt = 32'(w_tot_cnt);
            BSTAT_TAKEN: w_rdt = 32'(w_tk_cnt);
            BSTAT_MISP:  w_rdt = 32'(w_mp_cnt);
            default: begin
                w_rdt[FREEZE] = r_freeze;
                w_rdt[OVF]    = r_ovf;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack    <= 1'b0;
            r_rdt    <= '0;
            r_freeze <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_ack <= w_req;
            if (w_req)
                r_rdt <= w_rdt;
            if (w_ctrl_wr)
                r_freeze <= i_wb_dat[FREEZE];
            if (w_clr)
                r_ovf <= 1'b0;
            else if (w_tot_ovf || w_tk_ovf || w_mp_ovf)
                r_ovf <= 1'b1;
        end
    end

    // Snapshots sample pre-update live values, so a coincident clear is not seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branches <= '0;
            r_taken    <= '0;
        end else if (i_snap) begin
            r_branches <= w_tot_cnt;
            r_taken    <= w_tk_cnt;
        end
    end

    assign o_wb_ack   = r_ack;
    assign o_wb_rdt   = r_rdt;
    assign o_ovf      = r_ovf;
    assign o_branches = r_branches;
    assign o_taken    = r_taken;

endmodule
`default_nettype wire
